// File: rtl/mul_acc.sv
// Frame accumulator behind the 17x14 multiplier: sums NUM_ACC products, scales, saturates and
// presents the result on a valid/ready register. Define MUL_ACC_ROUND_EN for round-half-up scaling.
module mul_acc #(
    parameter int unsigned NUM_ACC = 8,
    parameter int unsigned ACC_W   = 34,
    parameter int unsigned SHIFT   = 3,
    parameter int unsigned OUT_W   = 24
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [30:0]      mul_out_i,
    input  logic             mul_done_i,
    output logic [OUT_W-1:0] acc_data_o,
    output logic             acc_sat_o,
    output logic             acc_valid_o,
    input  logic             acc_ready_i,
    output logic             busy_o,
    output logic             ovr_o
);

    localparam int unsigned CntW = $clog2(NUM_ACC);
    localparam int unsigned RW   = ACC_W + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NUM_ACC - 1);

`ifdef MUL_ACC_ROUND_EN
    // Half of one output LSB; evaluates to zero when SHIFT is zero.
    localparam logic [RW-1:0] Rnd = ({{ACC_W{1'b0}}, 1'b1} << SHIFT) >> 1;
`else
    localparam logic [RW-1:0] Rnd = '0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              done_q;
    logic [OUT_W-1:0]  data_q, data_d;
    logic              sat_q, sat_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;

    logic              prod_evt;
    logic [RW-1:0]     sum_rnd;
    logic [RW-1:0]     res;
    logic              res_sat;
    logic [OUT_W-1:0]  res_data;

    assign prod_evt = mul_done_i & ~done_q;

    // One extra bit so the rounding increment can never wrap the sum.
    always_comb begin
        sum_rnd  = {1'b0, acc_q} + Rnd;
        res      = sum_rnd >> SHIFT;
        res_sat  = |(res >> OUT_W);
        res_data = res_sat ? '1 : res[OUT_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (valid_q && acc_ready_i) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StAcc;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovr_d   = 1'b0;
                end
            end
            StAcc: begin
                if (prod_evt) begin
                    acc_d = acc_q + ACC_W'(mul_out_i);
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_d = StFin;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
                // A reload overrides a same-cycle handshake clear.
                if (!valid_q || acc_ready_i) begin
                    data_d  = res_data;
                    sat_d   = res_sat;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= mul_done_i;
            data_q  <= data_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign acc_data_o  = data_q;
    assign acc_sat_o   = sat_q;
    assign acc_valid_o = valid_q;
    assign busy_o      = (state_q != StIdle);
    assign ovr_o       = ovr_q;

endmodule

// File: tb/tb_mul_acc.sv
// Self-checking bench for mul_acc: directed frames plus random frames against an arithmetic model.
module tb_mul_acc;

    localparam int unsigned NUM_ACC = 8;
    localparam int unsigned ACC_W   = 34;
    localparam int unsigned SHIFT   = 3;
    localparam int unsigned OUT_W   = 24;

    logic             clk_i = 1'b0;
    logic             reset_n_i;
    logic             start_i;
    logic [30:0]      mul_out_i;
    logic             mul_done_i;
    logic [OUT_W-1:0] acc_data_o;
    logic             acc_sat_o;
    logic             acc_valid_o;
    logic             acc_ready_i;
    logic             busy_o;
    logic             ovr_o;

    int checks = 0;
    int errors = 0;

    logic [30:0]      prod_q[$];
    int               seen_k;
    logic [OUT_W-1:0] seen_data;
    logic             seen_sat;
    logic [OUT_W-1:0] exp_data;
    logic             exp_sat;

    always #5 clk_i = ~clk_i;

    mul_acc #(
        .NUM_ACC(NUM_ACC),
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W)
    ) dut (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .start_i    (start_i),
        .mul_out_i  (mul_out_i),
        .mul_done_i (mul_done_i),
        .acc_data_o (acc_data_o),
        .acc_sat_o  (acc_sat_o),
        .acc_valid_o(acc_valid_o),
        .acc_ready_i(acc_ready_i),
        .busy_o     (busy_o),
        .ovr_o      (ovr_o)
    );

    // Model: plain sum of the frame, optional half-LSB rounding, shift, clamp.
    function automatic void ref_result(output logic [OUT_W-1:0] d, output logic s);
        longint unsigned sum = 0;
        longint unsigned rnd = 0;
        longint unsigned r;
        longint unsigned maxv = (64'd1 << OUT_W) - 64'd1;
        foreach (prod_q[i]) sum += 64'(prod_q[i]);
`ifdef MUL_ACC_ROUND_EN
        if (SHIFT > 0) rnd = 64'd1 << (SHIFT - 1);
`endif
        r = (sum + rnd) >> SHIFT;
        s = (r > maxv);
        d = s ? OUT_W'(maxv) : OUT_W'(r);
    endfunction

    task automatic fill(input logic [30:0] v);
        prod_q.delete();
        for (int i = 0; i < NUM_ACC; i++) prod_q.push_back(v);
    endtask

    // Sends prod_q; seen_k is the negedge count after the last done rise when valid was seen.
    task automatic send_all(input int hold, input bit noise);
        for (int i = 0; i < prod_q.size() - 1; i++) begin
            mul_out_i  = prod_q[i];
            mul_done_i = 1'b1;
            if (noise) start_i = 1'($urandom_range(0, 1));
            repeat (hold) @(negedge clk_i);
            mul_done_i = 1'b0;
            start_i    = 1'b0;
            @(negedge clk_i);
        end
        mul_out_i  = prod_q[prod_q.size() - 1];
        mul_done_i = 1'b1;
        seen_k     = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            if (k == hold) mul_done_i = 1'b0;
            if (acc_valid_o) begin
                seen_k    = k;
                seen_data = acc_data_o;
                seen_sat  = acc_sat_o;
                break;
            end
        end
        mul_done_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic run_frame(input int hold, input bit pre_high, input bit noise);
        if (pre_high) begin
            mul_out_i  = 31'h1234;
            mul_done_i = 1'b1;
            @(negedge clk_i);
        end
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        if (pre_high) begin
            repeat (2) @(negedge clk_i);
            mul_done_i = 1'b0;
            @(negedge clk_i);
        end
        send_all(hold, noise);
    endtask

    task automatic test_reset();
        reset_n_i   = 1'b0;
        start_i     = 1'b0;
        mul_out_i   = '0;
        mul_done_i  = 1'b0;
        acc_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({acc_data_o, acc_sat_o, acc_valid_o, busy_o, ovr_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got data=%h sat=%b valid=%b busy=%b ovr=%b want all 0",
                     acc_data_o, acc_sat_o, acc_valid_o, busy_o, ovr_o);
        end
        reset_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_basic();
        fill(31'd1000);
        ref_result(exp_data, exp_sat);
        run_frame(1, 1'b0, 1'b0);
        checks++;
        if (seen_k !== 2) begin
            errors++;
            $display("FAIL t1_latency got %0d want 2", seen_k);
        end
        checks++;
        if (seen_data !== exp_data || seen_sat !== exp_sat) begin
            errors++;
            $display("FAIL t1_data got %0d/%b want %0d/%b", seen_data, seen_sat, exp_data, exp_sat);
        end
        checks++;
        if (acc_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL t1_idle_after got valid=%b busy=%b want 0 0", acc_valid_o, busy_o);
        end
    endtask

    task automatic test_sat();
        fill(31'h7FFF_FFFF);
        ref_result(exp_data, exp_sat);
        run_frame(1, 1'b0, 1'b0);
        checks++;
        if (seen_k !== 2 || seen_data !== 24'hFF_FFFF || seen_sat !== 1'b1) begin
            errors++;
            $display("FAIL t2_sat got k=%0d data=%h sat=%b want k=2 data=ffffff sat=1",
                     seen_k, seen_data, seen_sat);
        end
        checks++;
        if (seen_data !== exp_data || seen_sat !== exp_sat) begin
            errors++;
            $display("FAIL t2_model got %h/%b want %h/%b", seen_data, seen_sat, exp_data, exp_sat);
        end
    endtask

    task automatic test_round();
        logic [OUT_W-1:0] want;
`ifdef MUL_ACC_ROUND_EN
        want = 24'd2;
`else
        want = 24'd1;
`endif
        prod_q.delete();
        prod_q.push_back(31'd5);
        for (int i = 1; i < NUM_ACC; i++) prod_q.push_back(31'd1);
        run_frame(1, 1'b0, 1'b0);
        checks++;
        if (seen_k !== 2 || seen_data !== want || seen_sat !== 1'b0) begin
            errors++;
            $display("FAIL t3_round got k=%0d data=%0d sat=%b want k=2 data=%0d sat=0",
                     seen_k, seen_data, seen_sat, want);
        end
    endtask

    task automatic test_held_done();
        prod_q.delete();
        for (int i = 0; i < NUM_ACC; i++) prod_q.push_back(31'(100 + 10 * i));
        ref_result(exp_data, exp_sat);
        run_frame(5, 1'b1, 1'b0);
        checks++;
        if (seen_k !== 2 || seen_data !== exp_data || seen_sat !== exp_sat) begin
            errors++;
            $display("FAIL t4_held_done got k=%0d data=%0d want k=2 data=%0d",
                     seen_k, seen_data, exp_data);
        end
    endtask

    task automatic test_overrun();
        acc_ready_i = 1'b0;
        fill(31'd1000);
        run_frame(1, 1'b0, 1'b0);
        checks++;
        if (seen_k !== 2 || seen_data !== 24'd1000) begin
            errors++;
            $display("FAIL t5_frame1 got k=%0d data=%0d want k=2 data=1000", seen_k, seen_data);
        end
        fill(31'd2000);
        run_frame(1, 1'b0, 1'b0);
        repeat (2) @(negedge clk_i);
        checks++;
        if (acc_valid_o !== 1'b1 || acc_data_o !== 24'd1000 || ovr_o !== 1'b1) begin
            errors++;
            $display("FAIL t5_overrun got valid=%b data=%0d ovr=%b want 1 1000 1",
                     acc_valid_o, acc_data_o, ovr_o);
        end
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        checks++;
        if (ovr_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL t5_ovr_clear got ovr=%b busy=%b want 0 1", ovr_o, busy_o);
        end
        acc_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (acc_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL t5_drain got valid=%b want 0", acc_valid_o);
        end
        fill(31'd3000);
        send_all(2, 1'b0);
        checks++;
        if (seen_k !== 2 || seen_data !== 24'd3000 || ovr_o !== 1'b0) begin
            errors++;
            $display("FAIL t5_next got k=%0d data=%0d ovr=%b want 2 3000 0",
                     seen_k, seen_data, ovr_o);
        end
    endtask

    task automatic test_mid_reset();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mul_out_i  = 31'd50000;
            mul_done_i = 1'b1;
            @(negedge clk_i);
            mul_done_i = 1'b0;
            @(negedge clk_i);
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL t6_busy got %b want 1", busy_o);
        end
        reset_n_i = 1'b0;
        #1;
        checks++;
        if ({acc_data_o, acc_sat_o, acc_valid_o, busy_o, ovr_o} !== '0) begin
            errors++;
            $display("FAIL t6_async_reset got data=%h sat=%b valid=%b busy=%b ovr=%b want all 0",
                     acc_data_o, acc_sat_o, acc_valid_o, busy_o, ovr_o);
        end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        fill(31'd8);
        run_frame(1, 1'b0, 1'b0);
        checks++;
        if (seen_k !== 2 || seen_data !== 24'd8 || seen_sat !== 1'b0) begin
            errors++;
            $display("FAIL t6_new_frame got k=%0d data=%0d sat=%b want 2 8 0",
                     seen_k, seen_data, seen_sat);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 10; f++) begin
            int mode = int'($urandom_range(0, 2));
            prod_q.delete();
            for (int i = 0; i < NUM_ACC; i++) begin
                if (mode == 0)      prod_q.push_back(31'($urandom_range(0, 20'hF_FFFF)));
                else if (mode == 1) prod_q.push_back(31'($urandom));
                else                prod_q.push_back(31'($urandom_range(0, 24'hFF_FFFF)) << 3);
            end
            ref_result(exp_data, exp_sat);
            run_frame(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'b1);
            checks++;
            if (seen_k !== 2 || seen_data !== exp_data || seen_sat !== exp_sat) begin
                errors++;
                $display("FAIL rand_frame%0d got k=%0d data=%h sat=%b want k=2 data=%h sat=%b",
                         f, seen_k, seen_data, seen_sat, exp_data, exp_sat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat();
        test_round();
        test_held_done();
        test_overrun();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
